hsid_x_batch_fsm: RTL and testbench
===================================

Name: hsid_x_batch_fsm

Overview:
- Multi-pixel successor to the single-pixel HSID top sequencer. Processes a batch of N captured pixels against the HSP library without software intervention between pixels.
- For each pixel, it drives the OBI reader to fetch that pixel's band packs, then fetches the library in bounded bursts. It waits for the MSE core to finish the pixel, then advances to the next pixel.
- Sits between the register interface and the OBI read master / MSE compute core. Raises one sticky-status interrupt per batch.

Parameters:
- WORD_WIDTH, 32, OBI data/address word width.
- HSP_BANDS_WIDTH, HSID_HSP_BANDS_WIDTH, width of band-count field.
- HSP_LIBRARY_WIDTH, HSID_HSP_LIBRARY_WIDTH, width of library-size field.
- PIXELS_WIDTH, 8, width of batch pixel count (up to 255 pixels).
- BURST_WIDTH, 6, log2 of max OBI words per library burst (64).
- MEM_ACCESS_WIDTH (localparam), HSP_BANDS_WIDTH+HSP_LIBRARY_WIDTH, OBI limit width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hsp_bands  in  HSP_BANDS_WIDTH  bands per pixel
- hsp_library_size  in  HSP_LIBRARY_WIDTH  library pixel count
- num_pixels  in  PIXELS_WIDTH  captured pixels in batch
- captured_pixel_addr  in  WORD_WIDTH  byte address of first captured pixel
- library_pixel_addr  in  WORD_WIDTH  byte address of library
- start  in  1  begin batch (sampled in IDLE only)
- clear  in  1  software cancel
- error  in  1  external error (OBI/core)
- irq_ack  in  1  clears sticky status
- mse_done  in  1  MSE core finished current pixel
- pixel_start  out  1  one-cycle pulse to MSE core before each pixel's reads
- pixel_idx  out  PIXELS_WIDTH  index of pixel in progress
- busy  out  1  high in any state except IDLE
- st_done, st_error, st_cancelled, st_cfg_err  out  1 each  sticky status
- interrupt  out  1  OR of sticky status bits
- obi_initial_addr  out  WORD_WIDTH  OBI burst start address
- obi_limit_in  out  MEM_ACCESS_WIDTH  OBI burst length in words
- obi_start  out  1  one-cycle OBI burst start pulse
- obi_done  in  1  OBI burst complete

Behaviour:
- Reset (async): state IDLE; all outputs 0 except obi_limit_in=1; all cfg registers and counters 0.
- Derived values, latched in CONFIG:
  - packs = (hsp_bands+1)>>1, computed in HSP_BANDS_WIDTH+1 bits with no overflow.
  - stride = packs<<2 bytes.
  - lib_words = packs*hsp_library_size, computed in MEM_ACCESS_WIDTH bits.
- States:
  - IDLE: if start && !clear, go to CONFIG; otherwise stay. If clear and start are asserted together, clear wins. A start in IDLE also clears all sticky bits.
  - CONFIG: latch inputs; cap_addr=captured_pixel_addr; pixel_idx=0.
    - num_pixels==0: go to DONE; no OBI traffic.
    - hsp_bands==0 or hsp_library_size==0: set st_cfg_err, go to IDLE.
    - Otherwise go to PIX_START.
  - PIX_START: pulse pixel_start; lib_addr=cfg lib addr; lib_rem=lib_words; go to START_CAP.
  - START_CAP: obi_initial_addr=cap_addr; obi_limit_in=packs; obi_start=1 for exactly one cycle; go to READ_CAP.
  - READ_CAP: wait for obi_done, then go to START_LIB.
  - START_LIB: chunk=min(lib_rem, 2^BURST_WIDTH); obi_initial_addr=lib_addr; obi_limit_in=chunk; pulse obi_start; go to READ_LIB.
  - READ_LIB: on obi_done, lib_addr+=chunk<<2 and lib_rem-=chunk. If lib_rem becomes 0, go to WAIT_MSE; otherwise go to START_LIB.
  - WAIT_MSE: on mse_done, go to NEXT_PIX. An mse_done seen in any other state is ignored.
  - NEXT_PIX: if pixel_idx==num_pixels-1, go to DONE; otherwise pixel_idx+=1, cap_addr+=stride, go to PIX_START.
  - DONE: set st_done, go to IDLE.
  - CLEAR: reset cfg/counters; obi_start=0; set st_cancelled if the cause was clear, st_error if the cause was error (both if both); go to IDLE.
- Cancel: clear||error in any state other than IDLE/DONE/CLEAR sends the FSM to CLEAR on the next edge, pre-empting every other transition including obi_done.
- An error pulse in IDLE sets st_error directly.
- obi_initial_addr and obi_limit_in hold stable from the START_* cycle until the matching obi_done.
- Address arithmetic wraps modulo 2^WORD_WIDTH; no error is raised on wrap.
- interrupt is combinational: st_done|st_error|st_cancelled|st_cfg_err.
- irq_ack clears all sticky bits. If irq_ack coincides with a status set, the set wins.
- start while busy is ignored.
- Reset mid-operation returns every output to its reset value immediately.

Decomposition:
- hsid_pkg:
  - Add hsid_x_batch_t enum with states IDLE, CONFIG, PIX_START, START_CAP, READ_CAP, START_LIB, READ_LIB, WAIT_MSE, NEXT_PIX, DONE, CLEAR.
  - Add constants HSID_PIXELS_WIDTH=8 and HSID_BURST_WIDTH=6.
- Sub-module hsid_x_burst_splitter:
  - Owns lib_addr, lib_rem and the chunk computation.
  - Interface: load, advance, chunk, addr, last.

Test Plan:
- bands=5, lib=3, num_pixels=2, cap=0x100, lib=0x800, BURST_WIDTH=6:
  - Pixel 0: cap burst (0x100,3), then lib burst (0x800,9).
  - Pixel 1: cap burst (0x10C,3), then lib burst (0x800,9).
  - After the final mse_done: st_done=1, interrupt=1, pixel_start pulsed twice.
- bands=16, lib=20, BURST_WIDTH=6 (lib_words=160): lib bursts (0x800,64), (0x900,64), (0xA00,32), then WAIT_MSE.
- clear asserted during READ_LIB of pixel 1: next cycle CLEAR, then IDLE; st_cancelled=1; no further obi_start; busy=0.
- num_pixels=0 with start: CONFIG→DONE→IDLE; zero obi_start pulses; st_done=1.
- hsp_bands=0 with start: st_cfg_err=1 and interrupt=1. irq_ack clears it; a simultaneous clear+start in IDLE is ignored.
- rst_n asserted during READ_CAP with obi_done arriving: outputs reset at once; the FSM is in IDLE after release.

Source files
------------

// File: rtl/hsid_pkg.sv
// Shared constants and state encoding for the HSID sequencer blocks.
package hsid_pkg;

    localparam int HSID_HSP_BANDS_WIDTH   = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;
    localparam int HSID_PIXELS_WIDTH      = 8;
    localparam int HSID_BURST_WIDTH       = 6;

    typedef enum logic [3:0] {
        IDLE,
        CONFIG,
        PIX_START,
        START_CAP,
        READ_CAP,
        START_LIB,
        READ_LIB,
        WAIT_MSE,
        NEXT_PIX,
        DONE,
        CLEAR
    } hsid_x_batch_t;

endpackage

// File: rtl/hsid_x_burst_splitter.sv
// Splits the library fetch into bursts of at most 2^BURST_WIDTH words and
// walks the library address as each burst completes.
module hsid_x_burst_splitter
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int MAW         = 16,
    parameter int BURST_WIDTH = HSID_BURST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  clr,
    input  logic [WORD_WIDTH-1:0] base_addr,
    input  logic [MAW-1:0]        total_words,
    output logic [MAW-1:0]        chunk,
    output logic [WORD_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [MAW:0] MAX_CHUNK = (MAW+1)'(2 ** BURST_WIDTH);

    logic [MAW-1:0]        rem_q, rem_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;

    // Current burst: whatever is left, capped at the maximum burst length.
    always_comb begin
        last  = ({1'b0, rem_q} <= MAX_CHUNK);
        chunk = last ? rem_q : MAX_CHUNK[MAW-1:0];
        addr  = addr_q;
    end

    // Load a fresh library pass, or step past a completed burst (wraps freely).
    always_comb begin
        rem_d  = rem_q;
        addr_d = addr_q;
        if (clr) begin
            rem_d  = '0;
            addr_d = '0;
        end else if (load) begin
            rem_d  = total_words;
            addr_d = base_addr;
        end else if (advance) begin
            rem_d  = rem_q - chunk;
            addr_d = addr_q + (WORD_WIDTH'(chunk) << 2);
        end
    end

    // Remaining-word and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            addr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/hsid_x_batch_fsm.sv
// Batch sequencer: for each captured pixel, fetch its band packs, stream the
// library in bounded bursts, wait for the MSE core, then move to the next pixel.
module hsid_x_batch_fsm
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = 32,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
    parameter int PIXELS_WIDTH      = HSID_PIXELS_WIDTH,
    parameter int BURST_WIDTH       = HSID_BURST_WIDTH,
    localparam int MEM_ACCESS_WIDTH = HSP_BANDS_WIDTH + HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
    input  logic [PIXELS_WIDTH-1:0]      num_pixels,
    input  logic [WORD_WIDTH-1:0]        captured_pixel_addr,
    input  logic [WORD_WIDTH-1:0]        library_pixel_addr,
    input  logic                         start,
    input  logic                         clear,
    input  logic                         error,
    input  logic                         irq_ack,
    input  logic                         mse_done,
    output logic                         pixel_start,
    output logic [PIXELS_WIDTH-1:0]      pixel_idx,
    output logic                         busy,
    output logic                         st_done,
    output logic                         st_error,
    output logic                         st_cancelled,
    output logic                         st_cfg_err,
    output logic                         interrupt,
    output logic [WORD_WIDTH-1:0]        obi_initial_addr,
    output logic [MEM_ACCESS_WIDTH-1:0]  obi_limit_in,
    output logic                         obi_start,
    input  logic                         obi_done
);

    localparam int MAW = MEM_ACCESS_WIDTH;
    localparam int PW  = HSP_BANDS_WIDTH + 1;

    hsid_x_batch_t state_q, state_d;

    logic [PW-1:0]           packs_q, packs_d;
    logic [MAW-1:0]          lib_words_q, lib_words_d;
    logic [WORD_WIDTH-1:0]   lib_base_q, lib_base_d;
    logic [WORD_WIDTH-1:0]   cap_addr_q, cap_addr_d;
    logic [PIXELS_WIDTH-1:0] num_pix_q, num_pix_d;
    logic [PIXELS_WIDTH-1:0] pixel_idx_q, pixel_idx_d;
    logic [WORD_WIDTH-1:0]   obi_addr_q, obi_addr_d;
    logic [MAW-1:0]          obi_limit_q, obi_limit_d;
    logic                    cause_clr_q, cause_clr_d, cause_err_q, cause_err_d;
    logic                    st_done_q, st_done_d, st_error_q, st_error_d;
    logic                    st_canc_q, st_canc_d, st_cfg_q, st_cfg_d;

    logic [PW-1:0]           cfg_packs;
    logic [MAW-1:0]          cfg_lib_words;
    logic                    cfg_bad, cancel, last_pix;
    logic [MAW-1:0]          split_chunk;
    logic [WORD_WIDTH-1:0]   split_addr;
    logic                    split_last;

    // Derived configuration and cancel/last-pixel qualifiers.
    always_comb begin
        cfg_packs     = (PW'(hsp_bands) + PW'(1)) >> 1;
        cfg_lib_words = MAW'(cfg_packs) * MAW'(hsp_library_size);
        cfg_bad       = (hsp_bands == '0) || (hsp_library_size == '0);
        cancel        = (clear || error) &&
                        !(state_q inside {IDLE, DONE, CLEAR});
        last_pix      = (pixel_idx_q == num_pix_q - PIXELS_WIDTH'(1));
    end

    hsid_x_burst_splitter #(
        .WORD_WIDTH (WORD_WIDTH),
        .MAW        (MAW),
        .BURST_WIDTH(BURST_WIDTH)
    ) u_split (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state_q == PIX_START),
        .advance    (state_q == READ_LIB && obi_done && !cancel),
        .clr        (state_q == CLEAR),
        .base_addr  (lib_base_q),
        .total_words(lib_words_q),
        .chunk      (split_chunk),
        .addr       (split_addr),
        .last       (split_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a cancel pre-empts every other transition.
    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                IDLE:      if (start && !clear) state_d = CONFIG;
                CONFIG:    if (num_pixels == '0) state_d = DONE;
                           else if (cfg_bad)     state_d = IDLE;
                           else                  state_d = PIX_START;
                PIX_START: state_d = START_CAP;
                START_CAP: state_d = READ_CAP;
                READ_CAP:  if (obi_done) state_d = START_LIB;
                START_LIB: state_d = READ_LIB;
                READ_LIB:  if (obi_done) state_d = split_last ? WAIT_MSE : START_LIB;
                WAIT_MSE:  if (mse_done) state_d = NEXT_PIX;
                NEXT_PIX:  state_d = last_pix ? DONE : PIX_START;
                DONE:      state_d = IDLE;
                CLEAR:     state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; burst address/limit held after each start.
    always_comb begin
        pixel_start      = (state_q == PIX_START);
        obi_start        = (state_q == START_CAP) || (state_q == START_LIB);
        busy             = (state_q != IDLE);
        obi_initial_addr = obi_addr_q;
        obi_limit_in     = obi_limit_q;
        if (state_q == START_CAP) begin
            obi_initial_addr = cap_addr_q;
            obi_limit_in     = MAW'(packs_q);
        end else if (state_q == START_LIB) begin
            obi_initial_addr = split_addr;
            obi_limit_in     = split_chunk;
        end
        pixel_idx    = pixel_idx_q;
        st_done      = st_done_q;
        st_error     = st_error_q;
        st_cancelled = st_canc_q;
        st_cfg_err   = st_cfg_q;
        interrupt    = st_done_q | st_error_q | st_canc_q | st_cfg_q;
    end

    // Config latch, pixel walk, burst hold registers and cancel cause.
    always_comb begin
        packs_d     = packs_q;
        lib_words_d = lib_words_q;
        lib_base_d  = lib_base_q;
        cap_addr_d  = cap_addr_q;
        num_pix_d   = num_pix_q;
        pixel_idx_d = pixel_idx_q;
        obi_addr_d  = obi_initial_addr;
        obi_limit_d = obi_limit_in;
        cause_clr_d = cause_clr_q;
        cause_err_d = cause_err_q;
        case (state_q)
            CONFIG: begin
                packs_d     = cfg_packs;
                lib_words_d = cfg_lib_words;
                lib_base_d  = library_pixel_addr;
                cap_addr_d  = captured_pixel_addr;
                num_pix_d   = num_pixels;
                pixel_idx_d = '0;
            end
            NEXT_PIX: if (!last_pix) begin
                pixel_idx_d = pixel_idx_q + PIXELS_WIDTH'(1);
                cap_addr_d  = cap_addr_q + (WORD_WIDTH'(packs_q) << 2);
            end
            CLEAR: begin
                packs_d     = '0;
                lib_words_d = '0;
                lib_base_d  = '0;
                cap_addr_d  = '0;
                num_pix_d   = '0;
                pixel_idx_d = '0;
                obi_addr_d  = '0;
                obi_limit_d = MAW'(1);
            end
            default: ;
        endcase
        if (cancel) begin
            cause_clr_d = clear;
            cause_err_d = error;
        end
    end

    // Sticky status: ack or a fresh start clears, any set in the same cycle wins.
    always_comb begin
        st_done_d  = st_done_q;
        st_error_d = st_error_q;
        st_canc_d  = st_canc_q;
        st_cfg_d   = st_cfg_q;
        if (irq_ack || (state_q == IDLE && start && !clear)) begin
            st_done_d  = 1'b0;
            st_error_d = 1'b0;
            st_canc_d  = 1'b0;
            st_cfg_d   = 1'b0;
        end
        if (state_q == DONE) st_done_d = 1'b1;
        if (state_q == CONFIG && !cancel && num_pixels != '0 && cfg_bad) st_cfg_d = 1'b1;
        if (state_q == CLEAR && cause_clr_q) st_canc_d = 1'b1;
        if (state_q == CLEAR && cause_err_q) st_error_d = 1'b1;
        if (state_q == IDLE && error) st_error_d = 1'b1;
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packs_q     <= '0;
            lib_words_q <= '0;
            lib_base_q  <= '0;
            cap_addr_q  <= '0;
            num_pix_q   <= '0;
            pixel_idx_q <= '0;
            obi_addr_q  <= '0;
            obi_limit_q <= MAW'(1);
            cause_clr_q <= 1'b0;
            cause_err_q <= 1'b0;
            st_done_q   <= 1'b0;
            st_error_q  <= 1'b0;
            st_canc_q   <= 1'b0;
            st_cfg_q    <= 1'b0;
        end else begin
            packs_q     <= packs_d;
            lib_words_q <= lib_words_d;
            lib_base_q  <= lib_base_d;
            cap_addr_q  <= cap_addr_d;
            num_pix_q   <= num_pix_d;
            pixel_idx_q <= pixel_idx_d;
            obi_addr_q  <= obi_addr_d;
            obi_limit_q <= obi_limit_d;
            cause_clr_q <= cause_clr_d;
            cause_err_q <= cause_err_d;
            st_done_q   <= st_done_d;
            st_error_q  <= st_error_d;
            st_canc_q   <= st_canc_d;
            st_cfg_q    <= st_cfg_d;
        end
    end

endmodule

// File: tb/tb_hsid_x_batch_fsm.sv
// Bench for hsid_x_batch_fsm: a burst-list model predicts every OBI request
// and pixel index; directed scenarios cover batches, cancel, config errors, reset.
module tb_hsid_x_batch_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  hsp_bands, hsp_library_size, num_pixels;
    logic [31:0] cap_base, lib_base;
    logic        start, clear, error, irq_ack, mse_done, obi_done;
    logic        pixel_start, busy, st_done, st_error, st_cancelled, st_cfg_err;
    logic        interrupt, obi_start;
    logic [7:0]  pixel_idx;
    logic [31:0] obi_initial_addr;
    logic [15:0] obi_limit_in;

    int          vectors = 0;
    int          miscompares = 0;
    int          pix_cnt = 0;
    int          nlib = 0;
    bit          hold_act = 1'b0;
    logic [31:0] hold_addr;
    logic [15:0] hold_lim;
    logic [31:0] exp_addr[$];
    logic [15:0] exp_lim[$];

    always #5 clk = ~clk;

    hsid_x_batch_fsm dut (
        .clk(clk), .rst_n(rst_n),
        .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size),
        .num_pixels(num_pixels), .captured_pixel_addr(cap_base),
        .library_pixel_addr(lib_base), .start(start), .clear(clear),
        .error(error), .irq_ack(irq_ack), .mse_done(mse_done),
        .pixel_start(pixel_start), .pixel_idx(pixel_idx), .busy(busy),
        .st_done(st_done), .st_error(st_error), .st_cancelled(st_cancelled),
        .st_cfg_err(st_cfg_err), .interrupt(interrupt),
        .obi_initial_addr(obi_initial_addr), .obi_limit_in(obi_limit_in),
        .obi_start(obi_start), .obi_done(obi_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: ordered list of bursts the batch must issue.
    task automatic build_expect(input int bands, input int lib, input int np,
                                input logic [31:0] cap, input logic [31:0] la);
        int packs, rem, c;
        logic [31:0] a;
        exp_addr.delete();
        exp_lim.delete();
        nlib  = 0;
        packs = (bands + 1) / 2;
        for (int p = 0; p < np; p++) begin
            exp_addr.push_back(cap + 32'(p * packs * 4));
            exp_lim.push_back(16'(packs));
            rem = packs * lib;
            a   = la;
            while (rem > 0) begin
                c = (rem > 64) ? 64 : rem;
                exp_addr.push_back(a);
                exp_lim.push_back(16'(c));
                a   = a + 32'(c * 4);
                rem = rem - c;
                if (p == 0) nlib++;
            end
        end
    endtask

    // Compare process: every request against the model, hold until done.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n || clear || error || !busy) hold_act = 1'b0;
            if (obi_start) begin
                if (exp_addr.size() == 0) begin
                    chk("obi_start_unexpected", obi_start, 1'b0);
                end else begin
                    hold_addr = exp_addr.pop_front();
                    hold_lim  = exp_lim.pop_front();
                    chk("burst_addr", obi_initial_addr, hold_addr);
                    chk("burst_limit", obi_limit_in, hold_lim);
                    hold_act = 1'b1;
                end
            end else if (hold_act) begin
                chk("addr_hold", obi_initial_addr, hold_addr);
                chk("limit_hold", obi_limit_in, hold_lim);
                if (obi_done) hold_act = 1'b0;
            end
            if (pixel_start) begin
                chk("pixel_idx", pixel_idx, pix_cnt);
                pix_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_obi_start();
        for (int i = 0; i < 100; i++) begin
            if (obi_start) return;
            tick();
        end
        chk("obi_start_seen", obi_start, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            tick();
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic serve_burst(input bit spur_mse);
        wait_obi_start();
        tick();
        mse_done = spur_mse;
        tick();
        mse_done = 1'b0;
        obi_done = 1'b1;
        tick();
        obi_done = 1'b0;
    endtask

    task automatic set_cfg(input int b, input int l, input int np,
                           input logic [31:0] ca, input logic [31:0] la);
        hsp_bands = 8'(b); hsp_library_size = 8'(l); num_pixels = 8'(np);
        cap_base = ca; lib_base = la;
    endtask

    task automatic pulse_start();
        pix_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clears_sticky", interrupt, 1'b0);
    endtask

    task automatic serve_pixel(input bit spur);
        serve_burst(spur);
        for (int c = 0; c < nlib; c++) serve_burst(1'b0);
        chk("waiting_mse_busy", busy, 1'b1);
        chk("waiting_mse_not_done", st_done, 1'b0);
        mse_done = 1'b1;
        tick();
        mse_done = 1'b0;
    endtask

    task automatic run_batch(input int np);
        pulse_start();
        for (int p = 0; p < np; p++) serve_pixel(p == 0);
        wait_idle();
    endtask

    initial begin
        start = 0; clear = 0; error = 0; irq_ack = 0; mse_done = 0; obi_done = 0;
        set_cfg(0, 0, 0, 32'h0, 32'h0);
        fork monitor(); join_none
        repeat (3) tick();

        // Reset values
        chk("rst_busy", busy, 1'b0);
        chk("rst_obi_start", obi_start, 1'b0);
        chk("rst_pixel_start", pixel_start, 1'b0);
        chk("rst_limit", obi_limit_in, 16'd1);
        chk("rst_addr", obi_initial_addr, 32'h0);
        chk("rst_status", {st_done, st_error, st_cancelled, st_cfg_err, interrupt}, 5'b0);
        chk("rst_pixel_idx", pixel_idx, 8'd0);
        rst_n = 1'b1;
        tick();

        // Two-pixel batch, single library burst
        build_expect(5, 3, 2, 32'h100, 32'h800);
        chk("model_n", exp_addr.size(), 4);
        chk("model_cap1", exp_addr[2], 32'h10C);
        chk("model_lib_lim", exp_lim[1], 16'd9);
        set_cfg(5, 3, 2, 32'h100, 32'h800);
        run_batch(2);
        chk("b1_st_done", st_done, 1'b1);
        chk("b1_irq", interrupt, 1'b1);
        chk("b1_pixel_starts", pix_cnt, 2);
        chk("b1_drained", exp_addr.size(), 0);

        // Library split into 64/64/32
        build_expect(16, 20, 1, 32'h200, 32'h800);
        chk("model2_lim1", exp_lim[1], 16'd64);
        chk("model2_addr2", exp_addr[2], 32'h900);
        chk("model2_addr3", exp_addr[3], 32'hA00);
        chk("model2_lim3", exp_lim[3], 16'd32);
        set_cfg(16, 20, 1, 32'h200, 32'h800);
        run_batch(1);
        chk("b2_st_done", st_done, 1'b1);
        chk("b2_drained", exp_addr.size(), 0);

        // Clear during READ_LIB of pixel 1
        build_expect(5, 3, 2, 32'h100, 32'h800);
        set_cfg(5, 3, 2, 32'h100, 32'h800);
        pulse_start();
        serve_pixel(1'b0);
        serve_burst(1'b0);
        wait_obi_start();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_in_clear_busy", busy, 1'b1);
        tick();
        chk("clr_busy", busy, 1'b0);
        chk("clr_cancelled", st_cancelled, 1'b1);
        chk("clr_error", st_error, 1'b0);
        chk("clr_done", st_done, 1'b0);
        chk("clr_irq", interrupt, 1'b1);
        repeat (10) tick();
        chk("clr_drained", exp_addr.size(), 0);

        // Empty batch
        build_expect(5, 3, 0, 32'h100, 32'h800);
        set_cfg(5, 3, 0, 32'h100, 32'h800);
        pulse_start();
        wait_idle();
        chk("np0_done", st_done, 1'b1);
        chk("np0_cancelled", st_cancelled, 1'b0);
        chk("np0_pixel_starts", pix_cnt, 0);

        // Zero bands -> config error; clear+start ignored; ack; error in IDLE
        set_cfg(0, 3, 2, 32'h100, 32'h800);
        pulse_start();
        wait_idle();
        chk("cfg_err", st_cfg_err, 1'b1);
        chk("cfg_irq", interrupt, 1'b1);
        chk("cfg_done", st_done, 1'b0);
        set_cfg(5, 3, 2, 32'h100, 32'h800);
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        tick();
        chk("clrstart_busy", busy, 1'b0);
        chk("clrstart_keeps_sticky", st_cfg_err, 1'b1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack_irq", interrupt, 1'b0);
        error = 1'b1;
        tick();
        error = 1'b0;
        chk("idle_err", st_error, 1'b1);
        chk("idle_err_busy", busy, 1'b0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;

        // Reset during READ_CAP with obi_done arriving
        build_expect(5, 3, 1, 32'h300, 32'h800);
        set_cfg(5, 3, 1, 32'h300, 32'h800);
        pulse_start();
        wait_obi_start();
        tick();
        obi_done = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_limit", obi_limit_in, 16'd1);
        chk("arst_addr", obi_initial_addr, 32'h0);
        exp_addr.delete();
        exp_lim.delete();
        tick();
        obi_done = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("arst_idle", busy, 1'b0);
        chk("arst_pixel_start", pixel_start, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
